// File: rtl/comp_cell_2_bit.sv
// Registered 2-bit unsigned magnitude comparator cell.
// Two 1-bit slices are merged MSB-first; the flags are registered, so the latency is one cycle.
module comp_cell_2_bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       lt,
    output logic       gt
);

    logic e1, l1, g1;
    logic e0, l0, g0;
    logic eq_d, lt_d, gt_d;
    logic eq_q, lt_q, gt_q;

    // Bit-level slice terms
    always_comb begin
        e1 = ~(a[1] ^ b[1]);
        l1 = ~a[1] & b[1];
        g1 = a[1] & ~b[1];
        e0 = ~(a[0] ^ b[0]);
        l0 = ~a[0] & b[0];
        g0 = a[0] & ~b[0];
    end

    // The LSB slice only decides when the MSBs tie
    always_comb begin
        eq_d = e1 & e0;
        lt_d = l1 | (e1 & l0);
        gt_d = g1 | (e1 & g0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_q <= 1'b0;
            lt_q <= 1'b0;
            gt_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
            lt_q <= lt_d;
            gt_q <= gt_d;
        end
    end

    assign eq = eq_q;
    assign lt = lt_q;
    assign gt = gt_q;

endmodule

// File: tb/tb_comp_cell_2_bit.sv
// Self-checking bench for comp_cell_2_bit.
// An arithmetic reference model is checked on every cycle, and directed literal checks pin that model.
module tb_comp_cell_2_bit;

    logic       clk;
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic       eq;
    logic       lt;
    logic       gt;

    int checks;
    int errors;

    // Model state: expected {eq,lt,gt}, valid once the first reset edge has been seen
    logic [2:0] exp_flags;
    logic       known;

    comp_cell_2_bit dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .eq  (eq),
        .lt  (lt),
        .gt  (gt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        known     = 1'b0;
        exp_flags = 3'b000;
    end

    always @(posedge clk) begin
        if (rst) begin
            exp_flags <= 3'b000;
            known     <= 1'b1;
        end else if (a == b) begin
            exp_flags <= 3'b100;
        end else if (a < b) begin
            exp_flags <= 3'b010;
        end else begin
            exp_flags <= 3'b001;
        end
    end

    always @(negedge clk) begin
        if (known) begin
            checks++;
            if ({eq, lt, gt} !== exp_flags) begin
                errors++;
                $display("FAIL model t=%0t: got eq/lt/gt=%b expected %b", $time, {eq, lt, gt},
                         exp_flags);
            end
            if (exp_flags != 3'b000) begin
                checks++;
                if ((32'(eq) + 32'(lt) + 32'(gt)) != 1) begin
                    errors++;
                    $display("FAIL onehot t=%0t: got eq/lt/gt=%b expected exactly one set",
                             $time, {eq, lt, gt});
                end
            end
        end
    end

    // Apply the inputs for one edge; return 1 time unit after that edge
    task automatic drive(input logic [1:0] va, input logic [1:0] vb, input logic vr);
        a   = va;
        b   = vb;
        rst = vr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] want);
        checks++;
        if ({eq, lt, gt} !== want) begin
            errors++;
            $display("FAIL %s: got eq/lt/gt=%b expected %b", name, {eq, lt, gt}, want);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a      = 2'b01;
        b      = 2'b00;
        rst    = 1'b1;

        drive(2'd1, 2'd0, 1'b1);
        check("reset_1", 3'b000);
        drive(2'd1, 2'd0, 1'b1);
        check("reset_2", 3'b000);
        drive(2'd1, 2'd0, 1'b0);
        check("post_reset_gt", 3'b001);

        for (int v = 0; v < 16; v++) begin
            logic [3:0] bv;
            bv = 4'(v);
            drive(bv[1:0], bv[3:2], 1'b0);
        end

        drive(2'd3, 2'd3, 1'b0);
        check("spot_3_3_eq", 3'b100);
        drive(2'd1, 2'd2, 1'b0);
        check("spot_1_2_lt", 3'b010);
        drive(2'd2, 2'd1, 1'b0);
        check("spot_2_1_gt", 3'b001);
        drive(2'd0, 2'd3, 1'b0);
        check("spot_0_3_lt", 3'b010);

        drive(2'b10, 2'b01, 1'b0);
        check("msb_prio_gt", 3'b001);
        drive(2'b01, 2'b10, 1'b0);
        check("msb_prio_lt", 3'b010);

        drive(2'd0, 2'd0, 1'b0);
        check("latency_eq", 3'b100);
        drive(2'd3, 2'd0, 1'b0);
        check("latency_gt", 3'b001);
        drive(2'd0, 2'd3, 1'b0);
        check("latency_lt", 3'b010);

        for (int i = 0; i < 3; i++) begin
            drive(2'd3, 2'd1, 1'b0);
            check("stream_gt", 3'b001);
        end
        drive(2'd3, 2'd1, 1'b1);
        check("midstream_reset", 3'b000);
        drive(2'd3, 2'd1, 1'b0);
        check("resume_gt", 3'b001);

        // A reset edge that coincides with an operand change still clears the flags
        drive(2'd0, 2'd2, 1'b1);
        check("reset_wins", 3'b000);
        drive(2'd0, 2'd2, 1'b0);
        check("after_reset_lt", 3'b010);

        for (int i = 0; i < 1000; i++) begin
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
